pwm_regs_mc: RTL and testbench

PWM_REGS_MC -- requirements
Module: pwm_regs_mc

---
 rtl/pwm_regs_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_pwm_regs_mc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_regs_mc.sv
// Register file for a multi-channel PWM: global timer control, per-channel compare/mode
// registers, shadowed period/compare transfer, sticky status and a registered interrupt.
module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [7:0]              data_write,
  output logic [7:0]              data_read,
  input  logic [CNT_W-1:0]        counter_val,
  input  logic                    update_evt,
  output logic [CNT_W-1:0]        period,
  output logic                    en,
  output logic                    count_reset,
  output logic                    upnotdown,
  output logic [7:0]              prescale,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [NUM_CH*8-1:0]     functions,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic                    irq
);

  localparam int MSB_W    = CNT_W - 8;
  localparam int CH_IDX_W = ADDR_W - 3;

  localparam logic [ADDR_W-1:0] A_PER_L   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_PER_M   = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_EN      = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_CRST    = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_CVAL_L  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CVAL_M  = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] A_PRESC   = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_UPDN    = ADDR_W'(8'h07);
  localparam logic [ADDR_W-1:0] A_SHD     = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(8'h09);
  localparam logic [ADDR_W-1:0] A_IRQEN   = ADDR_W'(8'h0A);
  localparam logic [ADDR_W-1:0] A_CH_BASE = ADDR_W'(8'h10);

  function automatic logic [CNT_W-1:0] set_lsb(input logic [CNT_W-1:0] cur,
                                               input logic [7:0]       b);
    set_lsb = {cur[CNT_W-1:8], b};
  endfunction

  function automatic logic [CNT_W-1:0] set_msb(input logic [CNT_W-1:0] cur,
                                               input logic [MSB_W-1:0] b);
    set_msb = {b, cur[7:0]};
  endfunction

  function automatic logic [7:0] get_msb(input logic [CNT_W-1:0] v);
    get_msb = 8'(v[CNT_W-1:8]);
  endfunction

  logic [CNT_W-1:0]              per_stg_q, per_stg_d, per_act_q, per_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  c1_stg_q, c1_stg_d, c1_act_q, c1_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  c2_stg_q, c2_stg_d, c2_act_q, c2_act_d;
  logic [NUM_CH-1:0][7:0]        func_q, func_d;
  logic [NUM_CH-1:0]             pwmen_q, pwmen_d;
  logic [7:0]                    presc_q, presc_d;
  logic                          en_q, en_d;
  logic                          updn_q, updn_d;
  logic                          shd_en_q, shd_en_d;
  logic                          force_q, force_d;
  logic                          cnt_rst_q, cnt_rst_d;
  logic [1:0]                    status_q, status_d;
  logic [1:0]                    irq_en_q, irq_en_d;
  logic                          irq_q, irq_d;

  logic [ADDR_W-1:0]   ch_off;
  logic [CH_IDX_W-1:0] ch_idx;
  logic                ch_hit;
  logic                xfer;
  logic [7:0]          rd_val;

  // Channel window: 8-byte slots from 0x10; slots at or beyond NUM_CH are unmapped.
  assign ch_off = addr - A_CH_BASE;
  assign ch_idx = ch_off[ADDR_W-1:3];
  assign ch_hit = (addr >= A_CH_BASE) && (ch_idx < CH_IDX_W'(NUM_CH));

  // A transfer is a shadowed period-boundary load or a forced load.
  assign xfer = force_q | (shd_en_q & update_evt);

  always_comb begin
    per_stg_d = per_stg_q;
    per_act_d = per_act_q;
    c1_stg_d  = c1_stg_q;
    c1_act_d  = c1_act_q;
    c2_stg_d  = c2_stg_q;
    c2_act_d  = c2_act_q;
    func_d    = func_q;
    pwmen_d   = pwmen_q;
    presc_d   = presc_q;
    en_d      = en_q;
    updn_d    = updn_q;
    shd_en_d  = shd_en_q;
    force_d   = 1'b0;
    cnt_rst_d = 1'b0;
    status_d  = status_q;
    irq_en_d  = irq_en_q;
    irq_d     = |(status_q & irq_en_q);

    // Active copies sample the pre-write staging value, so a coincident write lands next time.
    if (xfer || !shd_en_q) begin
      per_act_d = per_stg_q;
      c1_act_d  = c1_stg_q;
      c2_act_d  = c2_stg_q;
    end

    if (write) begin
      case (addr)
        A_PER_L: per_stg_d = set_lsb(per_stg_q, data_write);
        A_PER_M: per_stg_d = set_msb(per_stg_q, data_write[MSB_W-1:0]);
        A_EN:    en_d      = data_write[0];
        A_CRST:  cnt_rst_d = 1'b1;
        A_PRESC: presc_d   = data_write;
        A_UPDN:  updn_d    = data_write[0];
        A_SHD: begin
          shd_en_d = data_write[0];
          force_d  = data_write[1];
        end
        A_STAT:  status_d  = status_q & ~data_write[1:0];
        A_IRQEN: irq_en_d  = data_write[1:0];
        default: ;
      endcase

      if (ch_hit) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_idx == CH_IDX_W'(n)) begin
            case (ch_off[2:0])
              3'd0: c1_stg_d[n] = set_lsb(c1_stg_q[n], data_write);
              3'd1: c1_stg_d[n] = set_msb(c1_stg_q[n], data_write[MSB_W-1:0]);
              3'd2: c2_stg_d[n] = set_lsb(c2_stg_q[n], data_write);
              3'd3: c2_stg_d[n] = set_msb(c2_stg_q[n], data_write[MSB_W-1:0]);
              3'd4: func_d[n]   = data_write;
              3'd5: pwmen_d[n]  = data_write[0];
              default: ;
            endcase
          end
        end
      end
    end

    // Set beats a coincident write-1-to-clear.
    if (xfer)       status_d[0] = 1'b1;
    if (update_evt) status_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_stg_q <= '0;
      per_act_q <= '0;
      c1_stg_q  <= '0;
      c1_act_q  <= '0;
      c2_stg_q  <= '0;
      c2_act_q  <= '0;
      func_q    <= '0;
      pwmen_q   <= '0;
      presc_q   <= '0;
      en_q      <= 1'b0;
      updn_q    <= 1'b1;
      shd_en_q  <= 1'b0;
      force_q   <= 1'b0;
      cnt_rst_q <= 1'b0;
      status_q  <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      per_stg_q <= per_stg_d;
      per_act_q <= per_act_d;
      c1_stg_q  <= c1_stg_d;
      c1_act_q  <= c1_act_d;
      c2_stg_q  <= c2_stg_d;
      c2_act_q  <= c2_act_d;
      func_q    <= func_d;
      pwmen_q   <= pwmen_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      updn_q    <= updn_d;
      shd_en_q  <= shd_en_d;
      force_q   <= force_d;
      cnt_rst_q <= cnt_rst_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      A_PER_L:  rd_val = per_stg_q[7:0];
      A_PER_M:  rd_val = get_msb(per_stg_q);
      A_EN:     rd_val = {7'b0, en_q};
      A_CVAL_L: rd_val = counter_val[7:0];
      A_CVAL_M: rd_val = get_msb(counter_val);
      A_PRESC:  rd_val = presc_q;
      A_UPDN:   rd_val = {7'b0, updn_q};
      A_SHD:    rd_val = {7'b0, shd_en_q};
      A_STAT:   rd_val = {6'b0, status_q};
      A_IRQEN:  rd_val = {6'b0, irq_en_q};
      default:  ;
    endcase

    if (ch_hit) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == CH_IDX_W'(n)) begin
          case (ch_off[2:0])
            3'd0: rd_val = c1_stg_q[n][7:0];
            3'd1: rd_val = get_msb(c1_stg_q[n]);
            3'd2: rd_val = c2_stg_q[n][7:0];
            3'd3: rd_val = get_msb(c2_stg_q[n]);
            3'd4: rd_val = func_q[n];
            3'd5: rd_val = {7'b0, pwmen_q[n]};
            default: ;
          endcase
        end
      end
    end
  end

  assign data_read   = read ? rd_val : 8'h00;
  assign period      = per_act_q;
  assign compare1    = c1_act_q;
  assign compare2    = c2_act_q;
  assign functions   = func_q;
  assign pwm_en      = pwmen_q;
  assign prescale    = presc_q;
  assign en          = en_q;
  assign upnotdown   = updn_q;
  assign count_reset = cnt_rst_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Scoreboard bench for pwm_regs_mc: stimulus queues expected values tagged with the
// cycle they apply to; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_pwm_regs_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 8;

  localparam int S_RD = 0, S_PER = 1, S_C1 = 2, S_C2 = 3, S_CR = 4, S_IRQ = 5;
  localparam int S_EN = 6, S_PRE = 7, S_UD = 8, S_FN = 9, S_PWE = 10;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    read = 1'b0;
  logic                    write = 1'b0;
  logic [ADDR_W-1:0]       addr = '0;
  logic [7:0]              data_write = '0;
  logic [7:0]              data_read;
  logic [CNT_W-1:0]        counter_val = '0;
  logic                    update_evt = 1'b0;
  logic [CNT_W-1:0]        period;
  logic                    en;
  logic                    count_reset;
  logic                    upnotdown;
  logic [7:0]              prescale;
  logic [NUM_CH-1:0]       pwm_en;
  logic [NUM_CH*8-1:0]     functions;
  logic [NUM_CH*CNT_W-1:0] compare1;
  logic [NUM_CH*CNT_W-1:0] compare2;
  logic                    irq;

  pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .update_evt(update_evt), .period(period), .en(en), .count_reset(count_reset),
    .upnotdown(upnotdown), .prescale(prescale), .pwm_en(pwm_en), .functions(functions),
    .compare1(compare1), .compare2(compare2), .irq(irq)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] mon_act;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] get_sig(input int sel);
    case (sel)
      S_RD:    return 64'(data_read);
      S_PER:   return 64'(period);
      S_C1:    return 64'(compare1);
      S_C2:    return 64'(compare2);
      S_CR:    return 64'(count_reset);
      S_IRQ:   return 64'(irq);
      S_EN:    return 64'(en);
      S_PRE:   return 64'(prescale);
      S_UD:    return 64'(upnotdown);
      S_FN:    return 64'(functions);
      S_PWE:   return 64'(pwm_en);
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = get_sig(mon_e.sel);
      n_chk++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, due %0d)",
                 mon_e.name, mon_act, mon_e.val, cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sel, input logic [63:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write      = 1'b1;
    addr       = a;
    data_write = d;
    tick();
    write      = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] v, input string nm);
    read = 1'b1;
    addr = a;
    expect_sig(S_RD, 64'(v), nm);
    tick();
    read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    expect_sig(S_IRQ, 64'd0, "rst_irq");
    expect_sig(S_UD,  64'd1, "rst_upnotdown");
    expect_sig(S_PER, 64'd0, "rst_period");
    expect_sig(S_CR,  64'd0, "rst_count_reset");
    expect_sig(S_C1,  64'd0, "rst_compare1");
    expect_sig(S_EN,  64'd0, "rst_en");
    tick();
    rst_n = 1'b1;
    tick();

    n_chk++;
    if (upnotdown !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_rst_upnotdown: got %b, expected 1", upnotdown);
    end
    n_chk++;
    if (irq !== 1'b0 || period !== '0) begin
      n_fail++;
      $display("FAIL direct_rst_irq_period: irq=%b period=0x%0h", irq, period);
    end

    for (int a = 0; a <= 10; a++)
      rd(8'(a), (a == 7) ? 8'h01 : 8'h00, $sformatf("rst_rd_%02h", a));
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int o = 0; o < 6; o++)
        rd(8'(16 + 8 * ch + o), 8'h00, $sformatf("rst_rd_%02h", 16 + 8 * ch + o));
    expect_sig(S_IRQ, 64'd0, "rst_irq_after_reads");

    counter_val = 16'hA55A;
    rd(8'h04, 8'h5A, "cval_lsb");
    rd(8'h05, 8'hA5, "cval_msb");
    wr(8'h04, 8'hFF);
    rd(8'h04, 8'h5A, "cval_ro");

    // Unshadowed: active compare1 trails the staging write by one cycle.
    wr(8'h20, 8'h34);
    wr(8'h21, 8'h12);
    expect_sig(S_C1, 64'h0000_0034_0000_0000, "c1_ch2_lag");
    tick();
    expect_sig(S_C1, 64'h0000_1234_0000_0000, "c1_ch2");
    n_chk++;
    if (compare1[2*CNT_W +: CNT_W] !== 16'h1234) begin
      n_fail++;
      $display("FAIL direct_c1_ch2: got 0x%0h, expected 0x1234", compare1[2*CNT_W +: CNT_W]);
    end
    rd(8'h21, 8'h12, "c1_ch2_rd_msb");
    rd(8'h20, 8'h34, "c1_ch2_rd_lsb");
    wr(8'h1A, 8'hCD);
    wr(8'h1B, 8'hAB);
    tick();
    expect_sig(S_C2, 64'h0000_0000_ABCD_0000, "c2_ch1");

    wr(8'h02, 8'hFF);
    expect_sig(S_EN, 64'd1, "en_set");
    rd(8'h02, 8'h01, "en_rd");
    wr(8'h06, 8'h5C);
    expect_sig(S_PRE, 64'h5C, "prescale");
    wr(8'h07, 8'h00);
    expect_sig(S_UD, 64'd0, "upnotdown_clr");
    rd(8'h07, 8'h00, "upnotdown_rd");
    wr(8'h1C, 8'hA7);
    expect_sig(S_FN, 64'h0000_A700, "functions_ch1");
    wr(8'h1D, 8'h03);
    expect_sig(S_PWE, 64'h2, "pwm_en_ch1");
    rd(8'h1D, 8'h01, "pwm_en_rd");

    // Shadowed period: held until update_evt.
    wr(8'h08, 8'h01);
    wr(8'h0A, 8'h01);
    wr(8'h00, 8'hFF);
    wr(8'h01, 8'h00);
    expect_sig(S_PER, 64'd0, "per_held_0");
    tick();
    expect_sig(S_PER, 64'd0, "per_held_1");
    rd(8'h00, 8'hFF, "per_stg_rd");
    rd(8'h09, 8'h00, "status_idle");
    rd(8'h08, 8'h01, "shadow_rd");
    update_evt = 1'b1;
    expect_sig(S_PER, 64'd0, "per_evt_cycle");
    tick();
    update_evt = 1'b0;
    expect_sig(S_PER, 64'h00FF, "per_loaded");
    expect_sig(S_IRQ, 64'd0, "irq_lat");
    rd(8'h09, 8'h03, "status_after_evt");
    expect_sig(S_IRQ, 64'd1, "irq_set");

    // Coincident staging write and transfer: old staging value moves.
    wr(8'h00, 8'h22);
    expect_sig(S_PER, 64'h00FF, "per_before_coinc");
    write      = 1'b1;
    addr       = 8'h00;
    data_write = 8'h33;
    update_evt = 1'b1;
    tick();
    write      = 1'b0;
    update_evt = 1'b0;
    expect_sig(S_PER, 64'h0022, "per_old_stg");
    rd(8'h00, 8'h33, "per_new_stg_rd");
    update_evt = 1'b1;
    tick();
    update_evt = 1'b0;
    expect_sig(S_PER, 64'h0033, "per_new_stg");

    // Forced load coinciding with a clear of UPD_DONE: set wins.
    wr(8'h09, 8'h03);
    wr(8'h00, 8'h80);
    wr(8'h08, 8'h03);
    wr(8'h09, 8'h01);
    expect_sig(S_PER, 64'h0080, "per_forced");
    rd(8'h09, 8'h01, "status_set_wins");
    expect_sig(S_IRQ, 64'd1, "irq_after_force");
    rd(8'h08, 8'h01, "force_reads_0");
    wr(8'h09, 8'h01);
    expect_sig(S_IRQ, 64'd1, "irq_lat_clear");
    rd(8'h09, 8'h00, "status_cleared");
    expect_sig(S_IRQ, 64'd0, "irq_dropped");

    // Back-to-back counter-reset writes.
    write      = 1'b1;
    addr       = 8'h03;
    data_write = 8'h00;
    tick();
    expect_sig(S_CR, 64'd1, "cnt_rst_1");
    n_chk++;
    if (count_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_cnt_rst_1: got %b, expected 1", count_reset);
    end
    tick();
    write = 1'b0;
    expect_sig(S_CR, 64'd1, "cnt_rst_2");
    tick();
    expect_sig(S_CR, 64'd0, "cnt_rst_end");
    rd(8'h03, 8'h00, "cnt_rst_rd");

    // Channel slot NUM_CH and other unmapped addresses.
    wr(8'h30, 8'hFF);
    wr(8'h31, 8'hFF);
    wr(8'h34, 8'hFF);
    wr(8'h35, 8'h01);
    wr(8'h0B, 8'hFF);
    tick();
    expect_sig(S_C1,  64'h0000_1234_0000_0000, "unmapped_c1");
    expect_sig(S_C2,  64'h0000_0000_ABCD_0000, "unmapped_c2");
    expect_sig(S_FN,  64'h0000_A700, "unmapped_fn");
    expect_sig(S_PWE, 64'h2, "unmapped_pwe");
    expect_sig(S_PER, 64'h0080, "unmapped_per");
    rd(8'h30, 8'h00, "unmapped_rd_30");
    rd(8'h35, 8'h00, "unmapped_rd_35");
    rd(8'h34, 8'h00, "unmapped_rd_34");
    rd(8'h0B, 8'h00, "unmapped_rd_0b");

    // Reset while a forced load and a counter-reset write are pending.
    wr(8'h00, 8'h44);
    wr(8'h08, 8'h03);
    write      = 1'b1;
    addr       = 8'h03;
    data_write = 8'h00;
    #2;
    rst_n = 1'b0;
    tick();
    write = 1'b0;
    expect_sig(S_CR, 64'd0, "midrst_cr_held");
    tick();
    rst_n = 1'b1;
    tick();
    expect_sig(S_CR,  64'd0, "midrst_cr_after");
    expect_sig(S_PER, 64'd0, "midrst_period");
    expect_sig(S_EN,  64'd0, "midrst_en");
    rd(8'h09, 8'h00, "midrst_status");
    rd(8'h07, 8'h01, "midrst_upnotdown");
    rd(8'h08, 8'h00, "midrst_shadow");
    expect_sig(S_IRQ, 64'd0, "midrst_irq");
    expect_sig(S_CR,  64'd0, "midrst_cr_late");

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never sampled, expected 0x%0h", mon_e.name, mon_e.val);
    end
    if (n_fail != 0)
      $display("FAIL summary: %0d failing checks", n_fail);
    else
      $display("PASS summary: all checks passed");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
